// File: rtl/measure_rx.sv
// XGMII receive-side measurement engine: recognises IPv4/UDP test frames tagged with
// MAGIC_CODE, reports one-way latency, destination IP and per-second frame/byte counts.
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'h5445_5354
`endif

module measure_rx #(
    parameter logic [31:0] MAGIC_CODE = `MAGIC_CODE
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sec_oneshot,
    input  logic [31:0] global_counter,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [23:0] rx_latency,
    output logic [31:0] rx_ipv4_ip,
    output logic        rx_match,
    output logic [1:0]  fsm_state
);
    // No handshake: every XGMII word is consumed in the cycle it is presented.
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_DATA    = 2'd1;
    localparam logic [1:0]  ST_DROP    = 2'd2;
    localparam logic [63:0] START_WORD = 64'hd5555555555555fb;

    logic [1:0]  state;
    logic [7:0]  w;
    logic        bad;
    logic [31:0] t_rx;
    logic [31:0] ip;
    logic [31:0] ts;
    logic [31:0] pps_acc;
    logic [31:0] byte_acc;

    logic [7:0]  lane [8];
    logic        is_start;
    logic        term_hit;
    logic [2:0]  term_lane;
    logic        drop_end;
    logic [7:0]  below_term;
    logic        ctrl_before;
    logic [15:0] frame_bytes;
    logic [31:0] latency;
    logic        accept;
    logic [31:0] pps_next;
    logic [31:0] byte_next;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lane[i] = xgmii_rxd[8*i +: 8];
        end
    end

    // Scan from the top lane down so the lowest terminate lane wins.
    always_comb begin
        term_hit  = 1'b0;
        term_lane = 3'd0;
        drop_end  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (xgmii_rxc[i] && lane[i] == 8'hFD) begin
                term_hit  = 1'b1;
                term_lane = 3'(i);
            end
            if (xgmii_rxc[i] && (lane[i] == 8'hFD || lane[i] == 8'h07)) begin
                drop_end = 1'b1;
            end
        end
    end

    assign is_start    = (xgmii_rxc == 8'h01) && (xgmii_rxd == START_WORD);
    assign below_term  = (8'h01 << term_lane) - 8'h01;
    assign ctrl_before = |(xgmii_rxc & below_term);
    // 8*(w-1)+L; w saturates at 255 so this never exceeds 16'hFFFF.
    assign frame_bytes = {5'd0, w - 8'd1, term_lane};
    assign latency     = t_rx - ts;
    assign accept      = (state == ST_DATA) && !is_start && term_hit && !bad &&
                         (w >= 8'd9) && !ctrl_before;
    assign fsm_state   = state;

    assign pps_next  = accept ? 32'd1 : 32'd0;
    assign byte_next = accept ? {16'd0, frame_bytes} : 32'd0;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            w     <= 8'd0;
            bad   <= 1'b0;
            t_rx  <= 32'd0;
            ip    <= 32'd0;
            ts    <= 32'd0;
        end else if (is_start) begin
            // A start word restarts capture from any state, aborting a frame in flight.
            state <= ST_DATA;
            w     <= 8'd1;
            bad   <= 1'b0;
            t_rx  <= global_counter;
        end else begin
            case (state)
                ST_DATA: begin
                    if (term_hit) begin
                        state <= ST_IDLE;
                    end else if (|xgmii_rxc) begin
                        state <= ST_DROP;
                    end else begin
                        w <= (w == 8'hFF) ? w : w + 8'd1;
                        case (w)
                            8'd2: if ({lane[4], lane[5]} != 16'h0800 || lane[6] != 8'h45) bad <= 1'b1;
                            8'd3: if (lane[7] != 8'h11) bad <= 1'b1;
                            8'd4: ip[31:16] <= {lane[6], lane[7]};
                            8'd5: ip[15:0]  <= {lane[0], lane[1]};
                            8'd6: begin
                                if ({lane[2], lane[3], lane[4], lane[5]} != MAGIC_CODE) bad <= 1'b1;
                                ts[31:16] <= {lane[6], lane[7]};
                            end
                            8'd7: ts[15:0] <= {lane[0], lane[1]};
                            default: ;
                        endcase
                    end
                end
                ST_DROP: begin
                    if (drop_end) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_match      <= 1'b0;
            rx_latency    <= 24'd0;
            rx_ipv4_ip    <= 32'd0;
            rx_pps        <= 32'd0;
            rx_throughput <= 32'd0;
            pps_acc       <= 32'd0;
            byte_acc      <= 32'd0;
        end else begin
            rx_match <= accept;
            if (accept) begin
                rx_latency <= (latency[31:24] != 8'd0) ? 24'hFF_FFFF : latency[23:0];
                rx_ipv4_ip <= ip;
            end
            // A frame accepted on the window boundary seeds the new window.
            if (sec_oneshot) begin
                rx_pps        <= pps_acc;
                rx_throughput <= byte_acc;
                pps_acc       <= pps_next;
                byte_acc      <= byte_next;
            end else if (accept) begin
                pps_acc  <= sat_add(pps_acc, pps_next);
                byte_acc <= sat_add(byte_acc, byte_next);
            end
        end
    end
endmodule

// File: tb/tb_measure_rx.sv
// Directed and randomized frames for measure_rx, checked against a byte-offset frame model
// that tracks expected latency, destination IP and per-second counters.
module tb_measure_rx;
    localparam logic [31:0] MAGIC = 32'hC0DE_1234;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        sec_oneshot = 1'b0;
    logic [31:0] global_counter = 32'd0;
    logic [63:0] xgmii_rxd = 64'h0707070707070707;
    logic [7:0]  xgmii_rxc = 8'hFF;
    logic [31:0] rx_pps;
    logic [31:0] rx_throughput;
    logic [23:0] rx_latency;
    logic [31:0] rx_ipv4_ip;
    logic        rx_match;
    logic [1:0]  fsm_state;

    measure_rx #(.MAGIC_CODE(MAGIC)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .sec_oneshot    (sec_oneshot),
        .global_counter (global_counter),
        .xgmii_rxd      (xgmii_rxd),
        .xgmii_rxc      (xgmii_rxc),
        .rx_pps         (rx_pps),
        .rx_throughput  (rx_throughput),
        .rx_latency     (rx_latency),
        .rx_ipv4_ip     (rx_ipv4_ip),
        .rx_match       (rx_match),
        .fsm_state      (fsm_state)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;
    int match_cnt = 0;
    int exp_accepts = 0;

    logic [31:0] acc_pps = 32'd0;
    logic [31:0] acc_bytes = 32'd0;
    logic [31:0] exp_pps = 32'd0;
    logic [31:0] exp_tp = 32'd0;
    logic [23:0] m_lat = 24'd0;
    logic [31:0] m_ip = 32'd0;
    bit          pend_frame = 1'b0;
    bit          pend_acc = 1'b0;
    bit          pend_sec = 1'b0;
    string       pend_tag = "";

    logic [7:0] fb [0:1023];
    int         flen = 0;

    always @(negedge sys_clk) begin
        if (rx_match === 1'b1) match_cnt++;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic drive_word(input logic [63:0] d, input logic [7:0] c, input bit s);
        @(negedge sys_clk);
        if (pend_frame) begin
            check32({pend_tag, " match"}, 32'(rx_match), 32'(pend_acc));
            check32({pend_tag, " latency"}, 32'(rx_latency), 32'(m_lat));
            check32({pend_tag, " ip"}, rx_ipv4_ip, m_ip);
            pend_frame = 1'b0;
        end
        if (pend_sec) begin
            check32("window pps", rx_pps, exp_pps);
            check32("window bytes", rx_throughput, exp_tp);
            pend_sec = 1'b0;
        end
        xgmii_rxd = d;
        xgmii_rxc = c;
        sec_oneshot = s;
        global_counter = global_counter + 32'd1;
        if (s) begin
            exp_pps = acc_pps;
            exp_tp = acc_bytes;
            acc_pps = 32'd0;
            acc_bytes = 32'd0;
            pend_sec = 1'b1;
        end
    endtask

    task automatic idle(input bit s);
        drive_word(64'h0707070707070707, 8'hFF, s);
    endtask

    task automatic make_frame(input logic [31:0] ip, input logic [31:0] ts, input int len);
        for (int i = 0; i < 1024; i++) fb[i] = 8'($urandom_range(0, 255));
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[23] = 8'h11;
        {fb[30], fb[31], fb[32], fb[33]} = ip;
        {fb[42], fb[43], fb[44], fb[45]} = MAGIC;
        {fb[46], fb[47], fb[48], fb[49]} = ts;
        flen = len;
    endtask

    function automatic bit model_accept(input int err_pos);
        if (flen < 64) return 1'b0;
        if (err_pos >= 0 && err_pos < flen) return 1'b0;
        if ({fb[12], fb[13]} != 16'h0800 || fb[14] != 8'h45 || fb[23] != 8'h11) return 1'b0;
        if ({fb[42], fb[43], fb[44], fb[45]} != MAGIC) return 1'b0;
        return 1'b1;
    endfunction

    // cut > 0 sends only that many data words and no terminate.
    task automatic send_frame(input string tag, input logic [31:0] t_rx, input int err_pos,
                              input int cut, input bit sec_at_end);
        bit          acc;
        int          nw;
        int          pos;
        logic [63:0] d;
        logic [7:0]  c;
        logic [31:0] diff;
        acc = model_accept(err_pos);
        drive_word(64'hd5555555555555fb, 8'h01, 1'b0);
        global_counter = t_rx;
        nw = (cut > 0) ? cut : flen / 8 + 1;
        for (int k = 1; k <= nw; k++) begin
            d = 64'd0;
            c = 8'd0;
            for (int j = 0; j < 8; j++) begin
                pos = 8 * (k - 1) + j;
                if (pos < flen && pos == err_pos) begin
                    d[8*j +: 8] = 8'hFE; c[j] = 1'b1;
                end else if (pos < flen) begin
                    d[8*j +: 8] = fb[pos];
                end else if (pos == flen) begin
                    d[8*j +: 8] = 8'hFD; c[j] = 1'b1;
                end else begin
                    d[8*j +: 8] = 8'h07; c[j] = 1'b1;
                end
            end
            drive_word(d, c, (k == nw) && sec_at_end && (cut == 0));
        end
        if (cut == 0) begin
            if (acc) begin
                acc_pps = sat32(acc_pps, 32'd1);
                acc_bytes = sat32(acc_bytes, 32'(flen));
                diff = t_rx - {fb[46], fb[47], fb[48], fb[49]};
                m_lat = (diff > 32'h00FF_FFFF) ? 24'hFF_FFFF : diff[23:0];
                m_ip = {fb[30], fb[31], fb[32], fb[33]};
                exp_accepts++;
            end
            pend_frame = 1'b1;
            pend_acc = acc;
            pend_tag = tag;
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        sys_rst = 1'b1;
        #1;
        check32({tag, " rx_match"}, 32'(rx_match), 32'd0);
        check32({tag, " rx_latency"}, 32'(rx_latency), 32'd0);
        check32({tag, " rx_ipv4_ip"}, rx_ipv4_ip, 32'd0);
        check32({tag, " rx_pps"}, rx_pps, 32'd0);
        check32({tag, " rx_throughput"}, rx_throughput, 32'd0);
        check32({tag, " fsm idle"}, 32'(fsm_state), 32'd0);
        acc_pps = 32'd0; acc_bytes = 32'd0; m_lat = 24'd0; m_ip = 32'd0;
        pend_frame = 1'b0; pend_sec = 1'b0;
        xgmii_rxd = 64'h0707070707070707; xgmii_rxc = 8'hFF; sec_oneshot = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        int kind;
        int err;
        logic [31:0] t;
        logic [31:0] tsv;

        // Power-on reset
        async_reset("reset");
        idle(1'b0);

        // Nominal 64-byte frame
        make_frame(32'h0A00_1469, 32'h0000_1000, 64);
        send_frame("nominal", 32'h0000_1234, -1, 0, 1'b0);
        idle(1'b0);
        check32("nominal latency const", 32'(rx_latency), 32'h0000_0234);
        check32("nominal ip const", rx_ipv4_ip, 32'h0A00_1469);
        idle(1'b1);
        idle(1'b0);
        check32("nominal bytes const", rx_throughput, 32'd64);

        // Latency wrap and saturation
        make_frame(32'h0A00_0001, 32'hFFFF_FFF0, 64);
        send_frame("wrap", 32'h0000_0010, -1, 0, 1'b0);
        idle(1'b0);
        check32("wrap latency const", 32'(rx_latency), 32'h20);
        make_frame(32'h0A00_0002, 32'h0000_0000, 72);
        send_frame("saturate", 32'h0100_0000, -1, 0, 1'b0);
        idle(1'b0);
        check32("saturate latency const", 32'(rx_latency), 32'hFF_FFFF);

        // Filtering: bad magic, IPv6 ethertype, runt terminate at w5
        make_frame(32'h0B00_0001, 32'h10, 64);
        fb[43] = fb[43] ^ 8'h01;
        send_frame("bad magic", 32'h20, -1, 0, 1'b0);
        make_frame(32'h0B00_0002, 32'h10, 64);
        fb[12] = 8'h86; fb[13] = 8'hDD;
        send_frame("ipv6", 32'h20, -1, 0, 1'b0);
        make_frame(32'h0B00_0003, 32'h10, 36);
        send_frame("runt", 32'h20, -1, 0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        check32("filter window pps const", rx_pps, 32'd2);

        // Errors: FE in lane 3 of w4, then a clean frame; abort at w5
        make_frame(32'h0C00_0001, 32'h100, 64);
        send_frame("fe in w4", 32'h180, 27, 0, 1'b0);
        make_frame(32'h0C00_0002, 32'h100, 64);
        send_frame("after fe", 32'h190, -1, 0, 1'b0);
        make_frame(32'h0C00_0003, 32'h100, 64);
        send_frame("aborted", 32'h1A0, -1, 4, 1'b0);
        make_frame(32'h0C00_0004, 32'h100, 80);
        send_frame("after abort", 32'h1B0, -1, 0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        check32("error window pps const", rx_pps, 32'd2);

        // Ten back-to-back frames in one window
        for (int i = 0; i < 10; i++) begin
            make_frame(32'h0D00_0000 + 32'(i), 32'h50, 64);
            send_frame("b2b", 32'h60 + 32'(i), -1, 0, 1'b0);
        end
        idle(1'b1);
        idle(1'b0);
        check32("b2b pps const", rx_pps, 32'd10);
        check32("b2b bytes const", rx_throughput, 32'd640);

        // Frame accepted on the window boundary lands in the next window
        make_frame(32'h0E00_0001, 32'h70, 64);
        send_frame("boundary", 32'h80, -1, 0, 1'b1);
        idle(1'b0);
        check32("boundary old window const", rx_pps, 32'd0);
        idle(1'b1);
        idle(1'b0);
        check32("boundary new window const", rx_pps, 32'd1);

        // Randomized frames
        for (int r = 0; r < 30; r++) begin
            t = $urandom;
            tsv = ($urandom_range(0, 3) == 0) ? $urandom : t - 32'($urandom_range(0, 20000000));
            make_frame($urandom, tsv, $urandom_range(64, 200));
            kind = $urandom_range(0, 5);
            err = -1;
            if (kind == 3) begin
                fb[13] = 8'hDD;
            end else if (kind == 4) begin
                fb[42 + $urandom_range(0, 3)] ^= 8'h10;
            end else if (kind == 5) begin
                err = $urandom_range(0, flen - 1);
            end
            send_frame("random", t, err, 0, $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) idle($urandom_range(0, 9) == 0);
        end
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset in the middle of a frame, then a clean frame
        make_frame(32'h0F00_0001, 32'h10, 64);
        send_frame("pre reset", 32'h20, -1, 4, 1'b0);
        async_reset("mid-frame reset");
        make_frame(32'h0F00_0002, 32'h300, 64);
        send_frame("post reset", 32'h345, -1, 0, 1'b0);
        idle(1'b0);
        check32("post reset latency const", 32'(rx_latency), 32'h45);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        check32("total rx_match pulses", 32'(match_cnt), 32'(exp_accepts));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
